// File: rtl/branch_resolve_unit.sv
// Branch resolution in EX: decodes funct3 against comparator flags, checks the prediction,
// and drives a held redirect followed by a timed flush. Optional counters: BRANCH_STATS_EN.
module branch_resolve_unit #(
   parameter int FLUSH_CYCLES = 2,
   parameter int XLEN         = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            br_valid,
   output logic            o_br_ready,
   input  logic [2:0]      br_funct3,
   input  logic [XLEN-1:0] br_pc,
   input  logic [XLEN-1:0] br_imm,
   input  logic            br_pred_taken,
   output logic            o_unsigned_op,
   input  logic            cmp_lt,
   input  logic            cmp_eq,
   output logic            o_resolved_valid,
   output logic            o_taken,
   output logic            o_redirect_valid,
   input  logic            redirect_ready,
   output logic [XLEN-1:0] o_redirect_pc,
   output logic            o_flush,
   output logic            o_illegal,
   output logic            o_misaligned,
   output logic [31:0]     o_stat_branches,
   output logic [31:0]     o_stat_mispredicts,
   output logic [1:0]      dbg_state
);

   // Handshakes: a branch transfers on a rising edge where br_valid & o_br_ready;
   // a redirect transfers on a rising edge where o_redirect_valid & redirect_ready.
   // Either side's valid/ready outside those edges has no effect.
   typedef enum logic [1:0] {IDLE = 2'd0, REDIRECT = 2'd1, FLUSH = 2'd2} state_t;

   localparam int CW = $clog2(FLUSH_CYCLES + 1);

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   redir_pc_q, redir_pc_d;
   logic              resolved_q, taken_q, illegal_q, misal_q;

   logic              accept, taken, illegal, misaligned, issue;
   logic [XLEN-1:0]   target;

   assign o_unsigned_op = br_funct3[1];
   assign accept        = br_valid & (state_q == IDLE);

   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (br_funct3)
         3'b000:          taken = cmp_eq;
         3'b001:          taken = ~cmp_eq;
         3'b100, 3'b110:  taken = cmp_lt;
         3'b101, 3'b111:  taken = ~cmp_lt;
         default:         illegal = 1'b1;
      endcase
   end

   assign target     = taken ? (br_pc + br_imm) : (br_pc + XLEN'(4));
   assign misaligned = taken & (target[1:0] != 2'b00);
   // Illegal and misaligned branches never redirect, even if they disagree with the prediction.
   assign issue      = accept & ~illegal & ~misaligned & (taken ^ br_pred_taken);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      redir_pc_d = redir_pc_q;
      case (state_q)
         IDLE: begin
            if (issue) begin
               state_d    = REDIRECT;
               redir_pc_d = target;
            end
         end
         REDIRECT: begin
            if (redirect_ready) begin
               state_d = FLUSH;
               cnt_d   = CW'(FLUSH_CYCLES);
            end
         end
         FLUSH: begin
            if (cnt_q <= CW'(1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         redir_pc_q <= '0;
         resolved_q <= 1'b0;
         taken_q    <= 1'b0;
         illegal_q  <= 1'b0;
         misal_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         redir_pc_q <= redir_pc_d;
         resolved_q <= accept;
         taken_q    <= accept & taken;
         illegal_q  <= accept & illegal;
         misal_q    <= accept & misaligned;
      end
   end

   assign o_br_ready       = (state_q == IDLE);
   assign o_redirect_valid = (state_q == REDIRECT);
   assign o_flush          = (state_q == FLUSH);
   assign o_redirect_pc    = redir_pc_q;
   assign o_resolved_valid = resolved_q;
   assign o_taken          = taken_q;
   assign o_illegal        = illegal_q;
   assign o_misaligned     = misal_q;
   assign dbg_state        = state_q;

`ifdef BRANCH_STATS_EN
   logic [31:0] stat_br_q, stat_mp_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_br_q <= '0;
         stat_mp_q <= '0;
      end else begin
         if (accept) stat_br_q <= stat_br_q + 32'd1;
         if (issue)  stat_mp_q <= stat_mp_q + 32'd1;
      end
   end

   assign o_stat_branches    = stat_br_q;
   assign o_stat_mispredicts = stat_mp_q;
`else
   assign o_stat_branches    = '0;
   assign o_stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: driver pushes expected resolve/redirect
// results, a negedge monitor pops and compares them.
module tb_branch_resolve_unit;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            br_valid = 1'b0;
   logic            o_br_ready;
   logic [2:0]      br_funct3 = 3'b010;
   logic [XLEN-1:0] br_pc = '0;
   logic [XLEN-1:0] br_imm = '0;
   logic            br_pred_taken = 1'b0;
   logic            o_unsigned_op;
   logic            cmp_lt = 1'b0;
   logic            cmp_eq = 1'b0;
   logic            o_resolved_valid;
   logic            o_taken;
   logic            o_redirect_valid;
   logic            redirect_ready = 1'b0;
   logic [XLEN-1:0] o_redirect_pc;
   logic            o_flush;
   logic            o_illegal;
   logic            o_misaligned;
   logic [31:0]     o_stat_branches;
   logic [31:0]     o_stat_mispredicts;
   logic [1:0]      dbg_state;

   int checks   = 0;
   int failures = 0;

   logic [2:0]      exp_q[$];   // {taken, illegal, misaligned}
   logic [XLEN-1:0] rdr_q[$];

   branch_resolve_unit #(.FLUSH_CYCLES(2), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .br_valid(br_valid), .o_br_ready(o_br_ready),
      .br_funct3(br_funct3), .br_pc(br_pc), .br_imm(br_imm), .br_pred_taken(br_pred_taken),
      .o_unsigned_op(o_unsigned_op), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
      .o_resolved_valid(o_resolved_valid), .o_taken(o_taken),
      .o_redirect_valid(o_redirect_valid), .redirect_ready(redirect_ready),
      .o_redirect_pc(o_redirect_pc), .o_flush(o_flush), .o_illegal(o_illegal),
      .o_misaligned(o_misaligned), .o_stat_branches(o_stat_branches),
      .o_stat_mispredicts(o_stat_mispredicts), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // drivers
   task automatic wait_idle();
      int n = 0;
      while (o_br_ready !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      chk("wait_idle_timeout", {31'd0, o_br_ready}, 32'd1);
   endtask

   task automatic send(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                       input logic pred, input logic lt, input logic eq,
                       input logic [2:0] exp_res, input logic exp_rd, input logic [31:0] exp_pc);
      wait_idle();
      br_valid      = 1'b1;
      br_funct3     = f3;
      br_pc         = pc;
      br_imm        = imm;
      br_pred_taken = pred;
      cmp_lt        = lt;
      cmp_eq        = eq;
      exp_q.push_back(exp_res);
      if (exp_rd) rdr_q.push_back(exp_pc);
      step();
      br_valid = 1'b0;
   endtask

   task automatic finish_redirect();
      redirect_ready = 1'b1;
      step();
      redirect_ready = 1'b0;
      wait_idle();
   endtask

   // scoreboard monitor
   logic            prev_rv = 1'b0;
   logic [XLEN-1:0] held_pc = '0;
   always @(negedge clk) begin
      if (o_resolved_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_resolve", 32'd1, 32'd0);
         end else begin
            logic [2:0] e;
            e = exp_q.pop_front();
            chk("resolve_taken_illegal_misaligned", {29'd0, o_taken, o_illegal, o_misaligned}, {29'd0, e});
         end
      end
      if (o_redirect_valid === 1'b1 && !prev_rv) begin
         if (rdr_q.size() == 0) begin
            chk("unexpected_redirect", 32'd1, 32'd0);
         end else begin
            logic [XLEN-1:0] p;
            p = rdr_q.pop_front();
            chk("redirect_pc", o_redirect_pc, p);
         end
      end else if (o_redirect_valid === 1'b1 && prev_rv) begin
         chk("redirect_pc_stable", o_redirect_pc, held_pc);
      end
      prev_rv = (o_redirect_valid === 1'b1);
      held_pc = o_redirect_pc;
   end

   initial begin
      // reset state
      step(); step(); step();
      chk("rst_br_ready", {31'd0, o_br_ready}, 32'd1);
      chk("rst_resolved", {31'd0, o_resolved_valid}, 32'd0);
      chk("rst_redirect", {31'd0, o_redirect_valid}, 32'd0);
      chk("rst_redirect_pc", o_redirect_pc, 32'd0);
      chk("rst_flush", {31'd0, o_flush}, 32'd0);
      chk("rst_illegal", {31'd0, o_illegal}, 32'd0);
      chk("rst_unsigned_op", {31'd0, o_unsigned_op}, 32'd1);
      chk("rst_stat_br", o_stat_branches, 32'd0);
      rst = 1'b0;

      // BEQ correct-taken; stray redirect_ready in IDLE is ignored
      redirect_ready = 1'b1;
      send(3'b000, 32'h100, 32'h20, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 32'h0);
      chk("beq_no_redirect", {31'd0, o_redirect_valid}, 32'd0);
      chk("beq_no_flush", {31'd0, o_flush}, 32'd0);
      chk("beq_ready", {31'd0, o_br_ready}, 32'd1);
      redirect_ready = 1'b0;

      // BLT mispredict: held redirect, br_valid ignored while busy
      send(3'b100, 32'h200, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b0, 3'b100, 1'b1, 32'h1F8);
      for (int i = 0; i < 3; i++) begin
         chk("blt_redirect_held", {31'd0, o_redirect_valid}, 32'd1);
         chk("blt_redirect_pc", o_redirect_pc, 32'h1F8);
         chk("blt_not_ready", {31'd0, o_br_ready}, 32'd0);
         br_valid = (i == 1);
         step();
      end
      br_valid       = 1'b0;
      redirect_ready = 1'b1;
      step();
      redirect_ready = 1'b0;
      chk("blt_flush_c1", {31'd0, o_flush}, 32'd1);
      chk("blt_redirect_dropped", {31'd0, o_redirect_valid}, 32'd0);
      step();
      chk("blt_flush_c2", {31'd0, o_flush}, 32'd1);
      chk("blt_not_ready_flush", {31'd0, o_br_ready}, 32'd0);
      step();
      chk("blt_flush_end", {31'd0, o_flush}, 32'd0);
      chk("blt_ready_back", {31'd0, o_br_ready}, 32'd1);

      // BGEU at top of address space: correct, then mispredicted with wrap
      send(3'b111, 32'hFFFF_FFFC, 32'h10, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 32'h0);
      chk("bgeu_no_redirect", {31'd0, o_redirect_valid}, 32'd0);
      send(3'b111, 32'hFFFF_FFFC, 32'h10, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 32'h0000_000C);
      chk("bgeu_wrap_pc", o_redirect_pc, 32'h0000_000C);
      redirect_ready = 1'b1;   // ready in the first REDIRECT cycle
      step();
      redirect_ready = 1'b0;
      chk("bgeu_one_cycle_redirect", {31'd0, o_flush}, 32'd1);
      wait_idle();

      // illegal funct3 and unsigned_op tracking
      send(3'b010, 32'h300, 32'h40, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0, 32'h0);
      chk("illegal_no_redirect", {31'd0, o_redirect_valid}, 32'd0);
      send(3'b011, 32'h300, 32'h40, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 32'h0);
      for (int i = 0; i < 8; i++) begin
         br_funct3 = 3'(i);
         #1;
         chk("unsigned_op", {31'd0, o_unsigned_op}, 32'((i >> 1) & 1));
      end

      // BNE not taken correct; BNE taken misaligned (mispredicted but no redirect)
      send(3'b001, 32'h300, 32'h40, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 32'h0);
      send(3'b001, 32'h300, 32'h6, 1'b0, 1'b0, 1'b0, 3'b101, 1'b0, 32'h0);
      chk("misaligned_no_redirect", {31'd0, o_redirect_valid}, 32'd0);

      // rst during FLUSH
      send(3'b110, 32'h400, 32'h40, 1'b0, 1'b1, 1'b0, 3'b100, 1'b1, 32'h440);
      redirect_ready = 1'b1;
      step();
      redirect_ready = 1'b0;
      chk("bltu_in_flush", {31'd0, o_flush}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_flush_abort", {31'd0, o_flush}, 32'd0);
      chk("rst_flush_ready", {31'd0, o_br_ready}, 32'd1);

      // rst during REDIRECT (BGE not taken, predicted taken)
      send(3'b101, 32'h500, 32'h40, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 32'h504);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_redirect_abort", {31'd0, o_redirect_valid}, 32'd0);
      chk("rst_redirect_ready", {31'd0, o_br_ready}, 32'd1);
      step();

      // statistics: 5 branches, 2 mispredicts since the last reset
      send(3'b000, 32'h100, 32'h20, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 32'h0);
      send(3'b100, 32'h200, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b0, 3'b100, 1'b1, 32'h1F8);
      finish_redirect();
      send(3'b001, 32'h700, 32'h20, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 32'h0);
      send(3'b101, 32'h600, 32'h10, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 32'h610);
      finish_redirect();
      send(3'b011, 32'h800, 32'h20, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 32'h0);
      step();
`ifdef BRANCH_STATS_EN
      chk("stat_branches", o_stat_branches, 32'd5);
      chk("stat_mispredicts", o_stat_mispredicts, 32'd2);
`else
      chk("stat_branches_tied", o_stat_branches, 32'd0);
      chk("stat_mispredicts_tied", o_stat_mispredicts, 32'd0);
`endif

      step(); step();
      chk("resolve_queue_drained", exp_q.size(), 32'd0);
      chk("redirect_queue_drained", rdr_q.size(), 32'd0);

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL global_timeout: got no finish expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
